ram_port_arbiter: RTL

- Two-requester arbiter/sequencer in front of the single-port 1024x8 RAM (ram: clk, wr, rd, cs, addr[9:0], bidirectional data[7:0]).
- Serialises read/write requests from two clients onto the one RAM port, owns the cs/wr/rd strobes and the tri-state drive of the shared data bus, and returns read data with a valid pulse.
- Default arbitration is round-robin.

---
 rtl/ram_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
// Two-client arbiter/sequencer for a single-port RAM: serialises requests, drives cs/wr/rd and the shared data bus.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: fixed priority (client 0 wins ties) instead of round-robin.
module ram_port_arbiter #(
   parameter int AW     = 10,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          ram_cs,
   output logic          ram_wr,
   output logic          ram_rd,
   output logic [AW-1:0] ram_addr,
   inout  wire  [DW-1:0] ram_data
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WR      = 2'd1;
   localparam logic [1:0] S_RD      = 2'd2;
   localparam logic [1:0] S_RD_DONE = 2'd3;

   logic [1:0]       r_state;
   logic             r_owner;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cs;
   logic             r_wr;
   logic             r_rd;
   logic [AW-1:0]    r_addr;
   logic [DW-1:0]    r_wdata;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_rvalid0;
   logic             r_rvalid1;
   logic [DW-1:0]    r_rdata0;
   logic [DW-1:0]    r_rdata1;

   logic             w_any_req;
   logic             w_pick1;
   logic             w_we;

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Client granted most recently; resets to 1 so client 0 wins the first tie.
   logic             r_last;
`endif

   assign w_any_req = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign w_pick1 = req1 & ~req0;
`else
   assign w_pick1 = req1 & (~req0 | ~r_last);
`endif

   assign w_we = w_pick1 ? we1 : we0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_owner   <= 1'b0;
         r_cnt     <= '0;
         r_cs      <= 1'b0;
         r_wr      <= 1'b0;
         r_rd      <= 1'b0;
         r_addr    <= '0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
         r_last    <= 1'b1;
`endif
      end else begin
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_pick1;
                  r_addr  <= w_pick1 ? addr1 : addr0;
                  r_cs    <= 1'b1;
                  r_gnt0  <= ~w_pick1;
                  r_gnt1  <= w_pick1;
`ifndef RAM_ARB_FIXED_PRIO_EN
                  r_last  <= w_pick1;
`endif
                  if (w_we) begin
                     r_wr    <= 1'b1;
                     r_state <= S_WR;
                  end else begin
                     r_rd    <= 1'b1;
                     r_cnt   <= CNT_W'(RD_LAT - 1);
                     r_state <= S_RD;
                  end
               end
            end
            S_WR: begin
               r_cs    <= 1'b0;
               r_wr    <= 1'b0;
               r_state <= S_IDLE;
            end
            S_RD: begin
               // Read data is sampled on the closing edge of the last strobe cycle.
               if (r_cnt == '0) begin
                  r_cs  <= 1'b0;
                  r_rd  <= 1'b0;
                  if (r_owner) begin
                     r_rdata1  <= ram_data;
                     r_rvalid1 <= 1'b1;
                  end else begin
                     r_rdata0  <= ram_data;
                     r_rvalid0 <= 1'b1;
                  end
                  r_state <= S_RD_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RD_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_cs    <= 1'b0;
               r_wr    <= 1'b0;
               r_rd    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Write data needs no reset: the bus driver is gated by r_wr, which is reset.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && w_any_req) begin
         r_wdata <= w_pick1 ? wdata1 : wdata0;
      end
   end

   assign gnt0     = r_gnt0;
   assign gnt1     = r_gnt1;
   assign rvalid0  = r_rvalid0;
   assign rvalid1  = r_rvalid1;
   assign rdata0   = r_rdata0;
   assign rdata1   = r_rdata1;
   assign ram_cs   = r_cs;
   assign ram_wr   = r_wr;
   assign ram_rd   = r_rd;
   assign ram_addr = r_addr;
   assign ram_data = r_wr ? r_wdata : {DW{1'bz}};

endmodule
